// File: rtl/hpm_counter_bank.sv
// Hardware performance-monitor counter bank: parametrised event counters with
// thresholds, sticky overflow and a registered interrupt, served through a CSR port.
module hpm_counter_bank #(
   parameter int unsigned NumCounters  = 6,
   parameter int unsigned CounterWidth = 64,
   parameter int unsigned NumEvents    = 32,
   parameter int unsigned IncW         = 2,
   parameter int unsigned Xlen         = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            debug_mode_i,
   input  logic [11:0]                     addr_i,
   input  logic                            we_i,
   input  logic [Xlen-1:0]                 data_i,
   output logic [Xlen-1:0]                 data_o,
   output logic                            access_err_o,
   input  logic [NumEvents-1:0][IncW-1:0]  event_inc_i,
   input  logic [31:0]                     mcountinhibit_i,
   output logic                            perf_counter_irq_o
);

   localparam int unsigned SelW  = (NumEvents > 1) ? $clog2(NumEvents) : 1;
   localparam int unsigned CwExt = CounterWidth + 1;

   // Address bits [11:5] of each HPM window; index bits [4:0] select counter 3..31
   localparam logic [6:0] RegCntLo = 7'h58;  // 0xB03..0xB1F
   localparam logic [6:0] RegCntHi = 7'h5C;  // 0xB83..0xB9F
   localparam logic [6:0] RegEvt   = 7'h19;  // 0x323..0x33F
   localparam logic [6:0] RegThrLo = 7'h5E;  // 0xBC3..0xBDF
   localparam logic [6:0] RegThrHi = 7'h5F;  // 0xBE3..0xBFF

   logic [CounterWidth-1:0] cnt_q [NumCounters];
   logic [CounterWidth-1:0] cnt_d [NumCounters];
   logic [CounterWidth-1:0] thr_q [NumCounters];
   logic [CounterWidth-1:0] thr_d [NumCounters];
   logic [SelW-1:0]         sel_q [NumCounters];
   logic [SelW-1:0]         sel_d [NumCounters];
   logic [NumCounters-1:0]  ofie_q, ofie_d;
   logic [NumCounters-1:0]  of_q, of_d;
   logic [NumCounters-1:0]  hit;
   logic                    irq_q, irq_d;

   logic [4:0]        idx;
   logic [6:0]        region;
   logic              idx_ok;
   logic              is_cnt_lo, is_cnt_hi, is_evt, is_thr_lo, is_thr_hi;
   logic              any_hpm, hi_illegal, wr_ok;
   logic [63:0]       wdata, rdata;
   logic              wr_k;
   logic [IncW-1:0]   inc;
   logic [CwExt-1:0]  sum;
   logic              unused_inputs;

   assign idx    = addr_i[4:0];
   assign region = addr_i[11:5];
   assign idx_ok = (idx >= 5'd3);

   assign is_cnt_lo = idx_ok && (region == RegCntLo);
   assign is_cnt_hi = idx_ok && (region == RegCntHi);
   assign is_evt    = idx_ok && (region == RegEvt);
   assign is_thr_lo = idx_ok && (region == RegThrLo);
   assign is_thr_hi = idx_ok && (region == RegThrHi);

   assign any_hpm      = is_cnt_lo || is_cnt_hi || is_evt || is_thr_lo || is_thr_hi;
   assign hi_illegal   = (Xlen == 64) && (is_cnt_hi || is_thr_hi);
   assign access_err_o = hi_illegal || (we_i && !any_hpm);
   assign wr_ok        = we_i && any_hpm && !hi_illegal;

   assign wdata = 64'(data_i);

   // Read mux; unimplemented counter indices fall through to zero
   always_comb begin
      rdata = '0;
      for (int unsigned k = 0; k < NumCounters; k++) begin
         if (idx == 5'(k + 3)) begin
            if (is_cnt_lo) rdata = (Xlen == 32) ? 64'(cnt_q[k][31:0]) : 64'(cnt_q[k]);
            if (is_cnt_hi) rdata = 64'(cnt_q[k][CounterWidth-1:32]);
            if (is_evt)    rdata = 64'({of_q[k], ofie_q[k], 30'(sel_q[k])});
            if (is_thr_lo) rdata = (Xlen == 32) ? 64'(thr_q[k][31:0]) : 64'(thr_q[k]);
            if (is_thr_hi) rdata = 64'(thr_q[k][CounterWidth-1:32]);
         end
      end
      if (hi_illegal) rdata = '0;
   end

   assign data_o = Xlen'(rdata);

   // Counting, CSR writes (which win over counting on the same register) and hit detection
   always_comb begin
      hit  = '0;
      wr_k = 1'b0;
      inc  = '0;
      sum  = '0;
      for (int unsigned k = 0; k < NumCounters; k++) begin
         cnt_d[k]  = cnt_q[k];
         thr_d[k]  = thr_q[k];
         sel_d[k]  = sel_q[k];
         ofie_d[k] = ofie_q[k];
         of_d[k]   = of_q[k];

         wr_k = wr_ok && (idx == 5'(k + 3));
         inc  = '0;
         for (int unsigned e = 1; e < NumEvents; e++) begin
            if (sel_q[k] == SelW'(e)) inc = event_inc_i[e];
         end
         sum = CwExt'(cnt_q[k]) + CwExt'(inc);

         if (!debug_mode_i && !mcountinhibit_i[k + 3] &&
             !(wr_k && (is_cnt_lo || is_cnt_hi || is_evt))) begin
            cnt_d[k] = sum[CounterWidth-1:0];
            if (sum[CounterWidth]) of_d[k] = 1'b1;
         end

         if (wr_k && is_cnt_lo) begin
            cnt_d[k] = (Xlen == 32) ? {cnt_q[k][CounterWidth-1:32], wdata[31:0]}
                                    : wdata[CounterWidth-1:0];
         end
         if (wr_k && is_cnt_hi) cnt_d[k] = {wdata[CounterWidth-33:0], cnt_q[k][31:0]};
         if (wr_k && is_evt) begin
            sel_d[k]  = wdata[SelW-1:0];
            ofie_d[k] = wdata[30];
            of_d[k]   = wdata[31];
            cnt_d[k]  = '0;
         end
         if (wr_k && is_thr_lo) begin
            thr_d[k] = (Xlen == 32) ? {thr_q[k][CounterWidth-1:32], wdata[31:0]}
                                    : wdata[CounterWidth-1:0];
         end
         if (wr_k && is_thr_hi) thr_d[k] = {wdata[CounterWidth-33:0], thr_q[k][31:0]};

         hit[k] = ((thr_q[k] != '0) && (cnt_q[k] >= thr_q[k])) || (of_q[k] && ofie_q[k]);
      end
      irq_d = |hit;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned k = 0; k < NumCounters; k++) begin
            cnt_q[k] <= '0;
            thr_q[k] <= '0;
            sel_q[k] <= '0;
         end
         ofie_q <= '0;
         of_q   <= '0;
         irq_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         thr_q  <= thr_d;
         sel_q  <= sel_d;
         ofie_q <= ofie_d;
         of_q   <= of_d;
         irq_q  <= irq_d;
      end
   end

   assign perf_counter_irq_o = irq_q;

   // Event 0 is hard-wired to zero; low inhibit bits and spare data bits have no counter
   assign unused_inputs = ^{mcountinhibit_i, event_inc_i[0], wdata, rdata};

endmodule
